// File: rtl/strobe_sequencer.sv
// strobe_sequencer: multi-channel camera/flash strobe generator (48 MHz fabric).
// The asynchronous trigger is synchronised and edge-detected according to the
// mode register, then divided by a programmable ratio. Each divided event
// ("fire") launches an independent delay-then-pulse sequence on every channel.
//
// Ports:
//   clk48      in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   trig_in    in   asynchronous external trigger
//   cfg_we     in   register write strobe (one cycle per write)
//   cfg_addr   in   [7:0] register address
//   cfg_wdata  in   [CNT_W-1:0] register write data
//   fire       out  one-cycle pulse per divided trigger event
//   strobe_out out  [N_CH-1:0] strobe outputs, active-high
//   busy       out  [N_CH-1:0] channel in DELAY or PULSE
//   overrun    out  [N_CH-1:0] sticky: fire arrived while channel busy
//
// Register map: 0 divisor, 1 mode[1:0] (write also clears overrun),
//   2+2k delay of channel k, 3+2k width of channel k.
//
// Build option: define RETRIGGER_EN to make a fire on a busy channel restart
// its sequence instead of being ignored and flagged in overrun.

module strobe_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             i_fire,
  input  logic             i_ovr_clr,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_strobe,
  output logic             o_busy,
  output logic             o_overrun
);
`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_sdelay, r_swidth;
  logic             r_strobe, r_busy, r_ovr;
  logic             w_start;

  // A new sequence starts from IDLE, or from any state when retriggering.
  assign w_start = i_fire && (r_state == S_IDLE || RETRIG);

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sdelay <= '0;
      r_swidth <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (i_ovr_clr) r_ovr <= 1'b0;
      // Set wins over a same-cycle clear so no overrun is lost.
      if (i_fire && r_state != S_IDLE && !RETRIG) r_ovr <= 1'b1;

      if (w_start) begin
        r_sdelay <= i_delay;
        r_swidth <= i_width;
        r_cnt    <= '0;
        if (i_width == '0) begin
          r_state <= S_IDLE;  r_strobe <= 1'b0; r_busy <= 1'b0;
        end else if (i_delay == '0) begin
          r_state <= S_PULSE; r_strobe <= 1'b1; r_busy <= 1'b1;
        end else begin
          r_state <= S_DELAY; r_strobe <= 1'b0; r_busy <= 1'b1;
        end
      end else begin
        // Counters run 0..N-1 against the latched length, so the full
        // 2^CNT_W-1 range works without ever wrapping.
        case (r_state)
          S_DELAY: begin
            if (r_cnt == r_sdelay - ONE) begin
              r_cnt <= '0; r_state <= S_PULSE; r_strobe <= 1'b1;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          S_PULSE: begin
            if (r_cnt == r_swidth - ONE) begin
              r_cnt <= '0; r_state <= S_IDLE; r_strobe <= 1'b0; r_busy <= 1'b0;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_strobe  = r_strobe;
  assign o_busy    = r_busy;
  assign o_overrun = r_ovr;
endmodule

module strobe_sequencer #(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEF_WIDTH   = 480
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             trig_in,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic             fire,
  output logic [N_CH-1:0]  strobe_out,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  overrun
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]            r_div, r_ecnt;
  logic [1:0]                  r_mode;
  logic [N_CH-1:0][CNT_W-1:0]  r_delay, r_width;
  logic [SYNC_STAGES-1:0]      r_sync;
  logic [SYNC_STAGES:0]        r_prime;
  logic                        r_hist, r_qedge, r_fire;
  logic                        w_sync, w_edge, w_div_we, w_ovr_clr;
  logic [CNT_W-1:0]            w_div_m1;

  assign w_div_we  = cfg_we && cfg_addr == 8'd0;
  assign w_ovr_clr = cfg_we && cfg_addr == 8'd1;
  assign w_div_m1  = (r_div == '0) ? '0 : r_div - ONE;

  // Configuration registers.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_div  <= ONE;
      r_mode <= 2'd1;
      for (int k = 0; k < N_CH; k++) begin
        r_delay[k] <= '0;
        r_width[k] <= CNT_W'(DEF_WIDTH);
      end
    end else if (cfg_we) begin
      if (cfg_addr == 8'd0) r_div  <= cfg_wdata;
      if (cfg_addr == 8'd1) r_mode <= cfg_wdata[1:0];
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_addr == 8'(2 + 2*k)) r_delay[k] <= cfg_wdata;
        if (cfg_addr == 8'(3 + 2*k)) r_width[k] <= cfg_wdata;
      end
    end
  end

  // Trigger synchroniser and edge detector. r_prime blocks edge detection
  // until the chain and history hold real samples after reset, so a trigger
  // held high through reset does not look like a fresh rising edge.
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = r_prime[SYNC_STAGES] &&
                  ((r_mode[0] && w_sync && !r_hist) ||
                   (r_mode[1] && !w_sync && r_hist));

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prime <= '0;
      r_hist  <= 1'b0;
      r_qedge <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], trig_in};
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      r_hist  <= w_sync;
      r_qedge <= w_edge;
    end
  end

  // Edge divider; a divisor write restarts the count and wins over an edge.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_ecnt <= '0;
      r_fire <= 1'b0;
    end else begin
      r_fire <= 1'b0;
      if (w_div_we) begin
        r_ecnt <= '0;
      end else if (r_qedge) begin
        if (r_ecnt == w_div_m1) begin
          r_ecnt <= '0;
          r_fire <= 1'b1;
        end else begin
          r_ecnt <= r_ecnt + ONE;
        end
      end
    end
  end

  assign fire = r_fire;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    strobe_channel #(.CNT_W(CNT_W)) u_ch (
      .clk48     (clk48),
      .rst_n     (rst_n),
      .i_fire    (r_fire),
      .i_ovr_clr (w_ovr_clr),
      .i_delay   (r_delay[g]),
      .i_width   (r_width[g]),
      .o_strobe  (strobe_out[g]),
      .o_busy    (busy[g]),
      .o_overrun (overrun[g])
    );
  end
endmodule

// File: tb/tb_strobe_sequencer.sv
// Directed bench for strobe_sequencer with hand-computed expectations.
// A negedge monitor records fire count/cycles and per-channel strobe
// first/last/high-count so each scenario checks exact pulse placement.
module tb_strobe_sequencer;
  localparam int N_CH = 2;
  localparam int CNT_W = 32;

  logic             clk48 = 1'b0;
  logic             rst_n = 1'b0;
  logic             trig_in = 1'b0;
  logic             cfg_we = 1'b0;
  logic [7:0]       cfg_addr = '0;
  logic [CNT_W-1:0] cfg_wdata = '0;
  logic             fire;
  logic [N_CH-1:0]  strobe_out, busy, overrun;

  strobe_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .DEF_WIDTH(480)) dut (
    .clk48(clk48), .rst_n(rst_n), .trig_in(trig_in), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .fire(fire),
    .strobe_out(strobe_out), .busy(busy), .overrun(overrun)
  );

  always #10 clk48 = ~clk48;

  int cyc = 0;
  always @(posedge clk48) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int fire_cnt, fire_first, fire_last;
  int st_first [N_CH];
  int st_last  [N_CH];
  int st_hi    [N_CH];
  logic [N_CH-1:0] st_prev = '0;

  always @(negedge clk48) begin
    if (fire) begin
      if (fire_cnt == 0) fire_first = cyc;
      fire_last = cyc;
      fire_cnt++;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (strobe_out[c]) begin
        if (!st_prev[c]) st_first[c] = cyc;
        st_last[c] = cyc;
        st_hi[c]++;
      end
    end
    st_prev = strobe_out;
  end

  task automatic clr_mon();
    fire_cnt = 0; fire_first = -1; fire_last = -1;
    for (int c = 0; c < N_CH; c++) begin
      st_first[c] = -1; st_last[c] = -1; st_hi[c] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk48); #1;
    end
  endtask

  task automatic cfg(input logic [7:0] a, input logic [CNT_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  int c0, t, e2, e5;

  initial begin
    clr_mon();
    tick(3);
    chk("rst_fire", fire, 0);
    chk("rst_strobe", strobe_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(6);

    // Defaults: single rise, both channels 480 cycles from fire+1.
    clr_mon();
    trig_in = 1'b1; c0 = cyc;
    tick(20);
    chk("t1_busy_mid", busy, 2'b11);
    tick(480);
    chk("t1_fire_cnt", fire_cnt, 1);
    chk("t1_fire_cyc", fire_last, c0 + 4);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("t1_first%0d", c), st_first[c], c0 + 5);
      chk($sformatf("t1_last%0d", c), st_last[c], c0 + 484);
      chk($sformatf("t1_hi%0d", c), st_hi[c], 480);
    end
    chk("t1_overrun", overrun, 0);

    // Per-channel delay/width, then width 0 disables a channel.
    trig_in = 1'b0;
    cfg(8'd2, 10); cfg(8'd3, 5); cfg(8'd4, 0); cfg(8'd5, 1);
    tick(10);
    clr_mon();
    trig_in = 1'b1; c0 = cyc; t = c0 + 4;
    tick(40);
    chk("t3_first0", st_first[0], t + 11);
    chk("t3_last0", st_last[0], t + 15);
    chk("t3_hi0", st_hi[0], 5);
    chk("t3_first1", st_first[1], t + 1);
    chk("t3_hi1", st_hi[1], 1);
    trig_in = 1'b0;
    cfg(8'd5, 0);
    tick(10);
    clr_mon();
    trig_in = 1'b1;
    tick(40);
    chk("t3_w0_fire", fire_cnt, 1);
    chk("t3_w0_hi1", st_hi[1], 0);
    chk("t3_w0_hi0", st_hi[0], 5);
    chk("t3_w0_ovr", overrun, 0);

    // Divider 3 with both edges: 3 square periods -> fire on edges 3 and 6.
    trig_in = 1'b0;
    tick(10);
    cfg(8'd0, 3); cfg(8'd1, 3);
    tick(5);
    clr_mon();
    e2 = 0; e5 = 0;
    for (int i = 0; i < 6; i++) begin
      trig_in = ~trig_in;
      if (i == 2) e2 = cyc;
      if (i == 5) e5 = cyc;
      tick(6);
    end
    tick(10);
    chk("t2_fire_cnt", fire_cnt, 2);
    chk("t2_fire_first", fire_first, e2 + 4);
    chk("t2_fire_last", fire_last, e5 + 4);
    // Divisor write mid-count restarts from 0.
    clr_mon();
    for (int i = 0; i < 2; i++) begin trig_in = ~trig_in; tick(6); end
    tick(6);
    cfg(8'd0, 3);
    for (int i = 0; i < 2; i++) begin trig_in = ~trig_in; tick(6); end
    tick(10);
    chk("t2_restart_nofire", fire_cnt, 0);
    trig_in = ~trig_in;
    tick(10);
    chk("t2_restart_fire", fire_cnt, 1);
    cfg(8'd0, 1); cfg(8'd1, 1);
    trig_in = 1'b0;
    tick(10);

    // Fire during an active 100-cycle pulse at t+50.
    cfg(8'd2, 0); cfg(8'd3, 100);
    tick(3);
    clr_mon();
    trig_in = 1'b1; c0 = cyc; t = c0 + 4;
    tick(20);
    trig_in = 1'b0;
    tick(30);
    trig_in = 1'b1;
    tick(150);
    chk("t4_fire_cnt", fire_cnt, 2);
    chk("t4_first0", st_first[0], t + 1);
`ifdef RETRIGGER_EN
    chk("t4_last0", st_last[0], t + 150);
    chk("t4_hi0", st_hi[0], 150);
    chk("t4_overrun", overrun, 2'b00);
`else
    chk("t4_last0", st_last[0], t + 100);
    chk("t4_hi0", st_hi[0], 100);
    chk("t4_overrun", overrun, 2'b01);
    cfg(8'd1, 1);
    tick();
    chk("t4_ovr_clr", overrun, 2'b00);
`endif

    // Width write during active pulse affects only the next sequence.
    trig_in = 1'b0;
    tick(10);
    clr_mon();
    trig_in = 1'b1;
    tick(30);
    cfg(8'd3, 20);
    tick(100);
    chk("t5_hi_cur", st_hi[0], 100);
    trig_in = 1'b0;
    tick(5);
    clr_mon();
    trig_in = 1'b1;
    tick(40);
    chk("t5_hi_next", st_hi[0], 20);

    // Reset during DELAY, trigger held high afterwards.
    cfg(8'd2, 50);
    trig_in = 1'b0;
    tick(10);
    trig_in = 1'b1;
    tick(15);
    chk("t6_dly_busy", busy[0], 1);
    chk("t6_dly_strobe", strobe_out[0], 0);
    rst_n = 1'b0;
    tick();
    chk("t6_dly_rst_strobe", strobe_out, 0);
    chk("t6_dly_rst_busy", busy, 0);
    rst_n = 1'b1;
    clr_mon();
    tick(20);
    chk("t6_dly_nofire", fire_cnt, 0);
    chk("t6_dly_nohi", st_hi[0] + st_hi[1], 0);

    // Reset during PULSE (defaults: delay 0, width 480).
    trig_in = 1'b0;
    tick(10);
    clr_mon();
    trig_in = 1'b1;
    tick(20);
    chk("t6_pls_strobe", strobe_out, 2'b11);
    rst_n = 1'b0;
    tick();
    chk("t6_pls_rst_strobe", strobe_out, 0);
    chk("t6_pls_rst_busy", busy, 0);
    rst_n = 1'b1;
    clr_mon();
    tick(20);
    chk("t6_pls_nofire", fire_cnt, 0);
    chk("t6_pls_strobe_after", strobe_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
